inst_fetch_ctrl: RTL

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

---
 rtl/inst_fetch_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/inst_fetch_ctrl.sv
// Two-state instruction fetch controller: FETCH issues an imem request, EXEC holds the instruction and selects the next PC.
// Define INST_FETCH_PERF_EN to add the fetch_cnt / redirect_cnt performance counters.
module inst_fetch_ctrl #(
  parameter int ADDR_W = 32,
  parameter int TA_W = 26,
  parameter int IMM_W = 16,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              stall,
  input  logic              jump,
  input  logic              jr,
  input  logic [ADDR_W-1:0] jr_addr,
  input  logic [TA_W-1:0]   TA,
  input  logic [IMM_W-1:0]  imm16,
  input  logic [1:0]        br_type,
  input  logic              Equal,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  output logic [31:0]       inst_out,
  output logic [ADDR_W-1:0] pc_out,
`ifdef INST_FETCH_PERF_EN
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       redirect_cnt,
`endif
  output logic [ADDR_W-1:0] pc_plus4
);

  typedef enum logic {FETCH, EXEC} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] jump_tgt;
  logic [ADDR_W-1:0] imm_ext;
  logic [ADDR_W-1:0] br_off;
  logic              br_taken;
  logic              redirect;

  assign pc_plus4   = pc + ADDR_W'(4);
  assign pc_out     = pc;
  assign imem_addr  = pc;
  assign inst_valid = (state == EXEC);
  // The request is masked by RST so nothing is issued while reset is held.
  assign imem_req   = (state == FETCH) && !RST;

  generate
    if (ADDR_W > TA_W + 2) begin : g_jump_region
      assign jump_tgt = {pc_plus4[ADDR_W-1:TA_W+2], TA, 2'b00};
    end else begin : g_jump_full
      assign jump_tgt = {TA, 2'b00};
    end
  endgenerate

  assign imm_ext  = ADDR_W'($signed(imm16));
  assign br_off   = imm_ext << 2;
  assign br_taken = ((br_type == 2'b01) && Equal) || ((br_type == 2'b10) && !Equal);
  assign redirect = jr || jump || br_taken;

  always_comb begin
    next_pc = pc_plus4;
    if (jr)
      next_pc = jr_addr & ~ADDR_W'(3);
    else if (jump)
      next_pc = jump_tgt;
    else if (br_taken)
      next_pc = pc_plus4 + br_off;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= FETCH;
      pc       <= RESET_VEC;
      inst_out <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            inst_out <= imem_rdata;
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (!stall) begin
            pc    <= next_pc;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef INST_FETCH_PERF_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fetch_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      if (state == FETCH && imem_ack)
        fetch_cnt <= fetch_cnt + 32'd1;
      if (state == EXEC && !stall && redirect)
        redirect_cnt <= redirect_cnt + 32'd1;
    end
  end
`endif

endmodule
